// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Encoding 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
package serial_sub_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit full-subtractor cell: d = a - b - bi, bo = borrow out.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b, bi (inputs); d (difference bit), bo (borrow out).
module fs_bit (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   // Borrow when b exceeds a, or when a==b and a borrow is already pending.
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first through one fs_bit cell.
// Latency: out_valid rises WIDTH edges after the input-handshake edge (WIDTH+1 counting it).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, bin;
//        out_valid/out_ready with diff, bout (unsigned borrow), ovf (signed overflow).
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             brw_q, brw_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             cell_d;
   logic             cell_bo;

   fs_bit u_fs_bit (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .bi (brw_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      brw_d   = brw_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               brw_d   = bin;
               cnt_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            // Result fills from the top so bit 0 lands at res[0] after WIDTH shifts.
            res_d  = {cell_d, res_q[WIDTH-1:1]};
            brw_d  = cell_bo;
            if (cnt_q == CNT_LAST) begin
               // Park the counter at 0 so it never runs past WIDTH-1.
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         brw_q   <= brw_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake outputs come straight from the state register: no input-to-output path.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   // Outputs are only meaningful in DONE; res/brw stop moving once RUN ends.
   assign diff = res_q;
   assign bout = brw_q;
   // Overflow only possible when operand signs differ and the result sign leaves a's sign.
   assign ovf  = (a_msb_q ^ b_msb_q) & (res_q[WIDTH-1] ^ a_msb_q);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed WIDTH=8 vectors and corner sequences,
// plus randomised sweeps on WIDTH=16 and WIDTH=2 instances.
module tb_serial_subtractor;

   logic clk;
   logic rst_n;

   logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, ovf8;
   logic [7:0] a8, b8, diff8;

   logic        in_valid16, in_ready16, bin16, out_valid16, out_ready16, bout16, ovf16;
   logic [15:0] a16, b16, diff16;

   logic       in_valid2, in_ready2, bin2, out_valid2, out_ready2, bout2, ovf2;
   logic [1:0] a2, b2, diff2;

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .bin(bin8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .diff(diff8), .bout(bout8), .ovf(ovf8)
   );

   serial_subtractor #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16), .bin(bin16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .diff(diff16), .bout(bout16), .ovf(ovf16)
   );

   serial_subtractor #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2), .bin(bin2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .diff(diff2), .bout(bout2), .ovf(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   typedef struct packed {
      logic        ovf;
      logic        bout;
      logic [63:0] diff;
   } res_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the handshake edge.
   task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      int k;
      k = 0;
      while (!in_ready8 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("start8 in_ready", 64'(in_ready8), 64'd1);
      a8 = av;
      b8 = bv;
      bin8 = bi;
      in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
   endtask

   // lat counts clock edges with the handshake edge as 1; junk on the inputs meanwhile.
   task automatic wait_done8(output int lat);
      lat = 1;
      while (!out_valid8 && lat < 40) begin
         in_valid8 = 1'($urandom_range(0, 1));
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         bin8 = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      in_valid8 = 1'b0;
   endtask

   task automatic consume8();
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
   endtask

   task automatic sweep(input int w, input int n);
      res_t        q[$];
      res_t        e;
      int          sent, got, cyc, extra;
      logic [63:0] mask;
      sent = 0;
      got = 0;
      cyc = 0;
      extra = 0;
      mask = (64'd1 << w) - 64'd1;
      while (got < n && cyc < n * 80) begin
         logic        ir, ov, ob, oo, r, v, rbi;
         logic [63:0] od, ra, rb;
         logic [64:0] full;
         @(negedge clk);
         cyc++;
         if (w == 16) begin
            ir = in_ready16; ov = out_valid16; od = 64'(diff16); ob = bout16; oo = ovf16;
         end else begin
            ir = in_ready2; ov = out_valid2; od = 64'(diff2); ob = bout2; oo = ovf2;
         end
         r = ($urandom_range(0, 3) != 0);
         v = ($urandom_range(0, 1) == 1);
         if (ir && sent >= n) v = 1'b0;
         ra = {$urandom, $urandom} & mask;
         rb = {$urandom, $urandom} & mask;
         rbi = 1'($urandom_range(0, 1));
         if (w == 16) begin
            out_ready16 = r; in_valid16 = v; a16 = ra[15:0]; b16 = rb[15:0]; bin16 = rbi;
         end else begin
            out_ready2 = r; in_valid2 = v; a2 = ra[1:0]; b2 = rb[1:0]; bin2 = rbi;
         end
         if (ov && r) begin
            if (q.size() == 0) begin
               chk($sformatf("w%0d unexpected result", w), 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               chk($sformatf("w%0d result %0d", w, got), {61'd0, oo, ob, 1'b0}, {61'd0, e.ovf, e.bout, 1'b0});
               chk($sformatf("w%0d diff %0d", w, got), od, e.diff);
            end
            got++;
         end
         if (ir && v) begin
            full = {1'b0, ra} - {1'b0, rb} - 65'(rbi);
            e.diff = full[63:0] & mask;
            e.bout = full[w];
            e.ovf  = (ra[w-1] ^ rb[w-1]) & (full[w-1] ^ ra[w-1]);
            q.push_back(e);
            sent++;
         end
      end
      chk($sformatf("w%0d results vs accepted", w), 64'(got), 64'(sent));
      chk($sformatf("w%0d accepted count", w), 64'(sent), 64'(n));
      chk($sformatf("w%0d pending", w), 64'(q.size()), 64'd0);
      if (w == 16) begin
         in_valid16 = 1'b0; out_ready16 = 1'b1;
      end else begin
         in_valid2 = 1'b0; out_ready2 = 1'b1;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((w == 16) ? out_valid16 : out_valid2) extra++;
      end
      chk($sformatf("w%0d spurious results", w), 64'(extra), 64'd0);
   endtask

   initial begin
      vec_t vt[9];
      int   lat;
      int   seen;

      vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      vt[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
      vt[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vt[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
      vt[7] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
      vt[8] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

      rst_n = 1'b0;
      in_valid8 = 0;  out_ready8 = 0;  a8 = 0;  b8 = 0;  bin8 = 0;
      in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0; bin16 = 0;
      in_valid2 = 0;  out_ready2 = 0;  a2 = 0;  b2 = 0;  bin2 = 0;

      @(negedge clk);
      chk("reset in_ready", 64'(in_ready8), 64'd1);
      chk("reset out_valid", 64'(out_valid8), 64'd0);
      chk("reset outputs", {54'd0, diff8, bout8, ovf8}, 64'd0);
      chk("reset w16", {46'd0, in_ready16, out_valid16, diff16}, {46'd0, 2'b10, 16'd0});
      chk("reset w2", {60'd0, in_ready2, out_valid2, diff2}, {60'd0, 2'b10, 2'd0});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         start8(vt[i].a, vt[i].b, vt[i].bin);
         chk($sformatf("vec%0d in_ready in RUN", i), 64'(in_ready8), 64'd0);
         wait_done8(lat);
         chk($sformatf("vec%0d latency", i), 64'(lat), 64'd9);
         chk($sformatf("vec%0d diff", i), 64'(diff8), 64'(vt[i].diff));
         chk($sformatf("vec%0d bout/ovf", i), {62'd0, bout8, ovf8}, {62'd0, vt[i].bout, vt[i].ovf});
         chk($sformatf("vec%0d in_ready in DONE", i), 64'(in_ready8), 64'd0);
         consume8();
         chk($sformatf("vec%0d out_valid after handshake", i), 64'(out_valid8), 64'd0);
      end

      // Backpressure: result must sit still for 5 cycles with out_ready low.
      start8(8'h03, 8'h05, 1'b0);
      wait_done8(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold out_valid", 64'(out_valid8), 64'd1);
         chk("hold result", {54'd0, diff8, bout8, ovf8}, {54'd0, 8'hFE, 1'b1, 1'b0});
         chk("hold in_ready", 64'(in_ready8), 64'd0);
      end
      consume8();
      chk("release in_ready", 64'(in_ready8), 64'd1);

      // Reset while cnt==3: aborts immediately and produces no result.
      start8(8'h42, 8'h13, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort in_ready", 64'(in_ready8), 64'd1);
      chk("abort out_valid", 64'(out_valid8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid8) seen++;
      end
      chk("abort no result", 64'(seen), 64'd0);
      start8(8'h10, 8'h01, 1'b0);
      wait_done8(lat);
      chk("post-abort latency", 64'(lat), 64'd9);
      chk("post-abort result", {54'd0, diff8, bout8, ovf8}, {54'd0, 8'h0F, 1'b0, 1'b0});
      consume8();

      sweep(16, 1000);
      sweep(2, 1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
